// File: rtl/uart_pkg.sv
// Shared UART receiver types and default configuration.
// UART_RX_PARITY_EN adds the StParity state to the receiver FSM.
package uart_pkg;

    localparam int unsigned DefaultDataWidth  = 8;
    localparam int unsigned DefaultSysClkFreq = 50_000_000;
    localparam int unsigned DefaultBps        = 9_600;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StRecover
    } uart_rx_state_t;
`else
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StRecover
    } uart_rx_state_t;
`endif

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// The flop reset value is a parameter so an idle-high line can reset to 1.
module uart_sync2 #(
    parameter bit ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 by default, mid-bit sampling of a synchronized line.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
    parameter int unsigned SYS_CLK_FREQ = DefaultSysClkFreq,
    parameter int unsigned BPS          = DefaultBps
) (
    input  logic                  uart_clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_out,
    output logic                  rx_done,
    output logic                  frame_err
);

    localparam int unsigned CyclesPerBit = SYS_CLK_FREQ / BPS;
    localparam int unsigned HalfBit      = CyclesPerBit / 2;
    localparam int unsigned CycW         = $clog2(CyclesPerBit);
    localparam int unsigned BitW         = $clog2(DATA_WIDTH + 1);

    logic                  rx_s;
    logic                  rx_s_prev_q;
    uart_rx_state_t        state_q;
    logic [CycW-1:0]       cyc_q;
    logic [BitW-1:0]       bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] rx_out_q;
    logic                  rx_done_q;
    logic                  frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                  parity_err_q;
`endif

    uart_sync2 #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk_i (uart_clk),
        .rst_ni(rst_n),
        .d_i   (rx_in),
        .q_o   (rx_s)
    );

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s_prev_q  <= 1'b1;
            state_q      <= StIdle;
            cyc_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_out_q     <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_s_prev_q <= rx_s;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rx_s_prev_q && !rx_s) begin
                        state_q      <= StStart;
                        cyc_q        <= '0;
                        bit_cnt_q    <= '0;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= 1'b0;
`endif
                    end
                end
                StStart: begin
                    if (cyc_q == CycW'(HalfBit - 1)) begin
                        cyc_q   <= '0;
                        // A line already back high at mid-start is a glitch.
                        state_q <= rx_s ? StIdle : StData;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                StData: begin
                    if (cyc_q == CycW'(CyclesPerBit - 1)) begin
                        cyc_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (bit_cnt_q == BitW'(i)) begin
                                shift_q[i] <= rx_s;
                            end
                        end
                        if (bit_cnt_q == BitW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cyc_q == CycW'(CyclesPerBit - 1)) begin
                        cyc_q        <= '0;
                        parity_err_q <= (^shift_q) ^ rx_s;
                        state_q      <= StStop;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (cyc_q == CycW'(CyclesPerBit - 1)) begin
                        cyc_q <= '0;
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                            state_q     <= StRecover;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_err_q) begin
                            frame_err_q <= 1'b1;
                            state_q     <= StIdle;
`endif
                        end else begin
                            rx_out_q  <= shift_q;
                            rx_done_q <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                StRecover: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_out    = rx_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at 64 clocks per bit.
// Honours UART_RX_PARITY_EN when the design is built with it.
module tb_uart_rx_core;

    localparam int unsigned Dw   = 8;
    localparam int unsigned Freq = 50_000_000;
    localparam int unsigned Bps  = 781_250;
    localparam int unsigned Cpb  = Freq / Bps;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned ParBits = 1;
`else
    localparam int unsigned ParBits = 0;
`endif

    typedef struct packed {
        logic          is_err;
        logic [Dw-1:0] data;
    } exp_t;

    logic          uart_clk = 1'b0;
    logic          rst_n    = 1'b0;
    logic          rx_in    = 1'b1;
    logic [Dw-1:0] rx_out;
    logic          rx_done;
    logic          frame_err;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            last_done_cyc = -1;
    int            t_start;
    exp_t          exp_q[$];
    logic [Dw-1:0] prev_out = '0;

    uart_rx_core #(
        .DATA_WIDTH  (Dw),
        .SYS_CLK_FREQ(Freq),
        .BPS         (Bps)
    ) dut (
        .uart_clk (uart_clk),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .rx_out   (rx_out),
        .rx_done  (rx_done),
        .frame_err(frame_err)
    );

    always #5 uart_clk = ~uart_clk;
    always @(posedge uart_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expectation for every rx_done or frame_err pulse.
    always @(negedge uart_clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_out = rx_out;
        end else begin
            if (rx_done && frame_err) check("done_with_err", 32'd1, 32'd0);
            if (rx_out !== prev_out) check("rx_out_change_needs_done", 32'(rx_done), 32'd1);
            if (rx_done || frame_err) begin
                check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
                    check("rx_out_value", 32'(rx_out), 32'(e.data));
                end
                if (rx_done) last_done_cyc = cyc;
            end
            prev_out = rx_out;
        end
    end

    task automatic bit_time(input logic v);
        rx_in = v;
        repeat (Cpb) @(negedge uart_clk);
    endtask

    task automatic send_frame(input logic [Dw-1:0] d, input logic stop_bit, input logic flip_par);
        t_start = cyc;
        bit_time(1'b0);
        for (int i = 0; i < Dw; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^d) ^ flip_par);
`else
        if (flip_par) rx_in = 1'b1;
`endif
        bit_time(stop_bit);
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * Cpb) @(negedge uart_clk);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (5) @(negedge uart_clk);
        check("reset_rx_out", 32'(rx_out), 32'h0);
        check("reset_rx_done", 32'(rx_done), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        idle_bits(2);

        // Single frame and its latency from the start edge (~9.5 bits + sync).
        exp_q.push_back('{is_err: 1'b0, data: 8'h55});
        send_frame(8'h55, 1'b1, 1'b0);
        lat = last_done_cyc - t_start;
        check("done_latency_window",
              32'((lat >= int'((9 + ParBits) * Cpb + Cpb / 2) - 4) &&
                  (lat <= int'((9 + ParBits) * Cpb + Cpb / 2) + 8)), 32'd1);
        idle_bits(2);

        // Back-to-back frames with no idle gap.
        exp_q.push_back('{is_err: 1'b0, data: 8'hA3});
        exp_q.push_back('{is_err: 1'b0, data: 8'h0F});
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle_bits(2);

        // Short low glitch (well under half a bit): nothing expected.
        rx_in = 1'b0;
        repeat (12) @(negedge uart_clk);
        idle_bits(3);
        check("glitch_no_pulse", 32'(exp_q.size()), 32'd0);

        // Bad stop bit: frame_err, rx_out stays 0x0F, line held low afterwards.
        exp_q.push_back('{is_err: 1'b1, data: 8'h0F});
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (4 * Cpb) @(negedge uart_clk);
        check("recover_rx_out_kept", 32'(rx_out), 32'h0F);
        idle_bits(2);

        // Reset during data bit 4 aborts silently; then receive 0x81.
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1 ^ 1'(i));
        rx_in = 1'b0;
        repeat (Cpb / 2) @(negedge uart_clk);
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (10) @(negedge uart_clk);
        check("midframe_reset_rx_out", 32'(rx_out), 32'h0);
        rst_n = 1'b1;
        idle_bits(2);
        check("midframe_reset_no_pulse", 32'(exp_q.size()), 32'd0);
        exp_q.push_back('{is_err: 1'b0, data: 8'h81});
        send_frame(8'h81, 1'b1, 1'b0);
        idle_bits(1);

        // Extreme data words.
        exp_q.push_back('{is_err: 1'b0, data: 8'h00});
        send_frame(8'h00, 1'b1, 1'b0);
        idle_bits(1);
        exp_q.push_back('{is_err: 1'b0, data: 8'hFF});
        send_frame(8'hFF, 1'b1, 1'b0);
        idle_bits(1);
        check("final_rx_out", 32'(rx_out), 32'hFF);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back('{is_err: 1'b1, data: 8'hFF});
        send_frame(8'h5A, 1'b1, 1'b1);
        idle_bits(1);
        check("parity_err_rx_out_kept", 32'(rx_out), 32'hFF);
`endif

        repeat (2 * Cpb) @(negedge uart_clk);
        check("all_expected_pulses_seen", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter SYS_CLK_FREQ, default 50_000_000: uart_clk frequency in Hz.
REQ-003 Parameter BPS, default 9_600: line bit rate; CYCLES_PER_BIT = SYS_CLK_FREQ / BPS (5208 at defaults).
REQ-004 Port uart_clk  input  1: single clock; all logic on its rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port rx_in  input  1: serial line, idle high, asynchronous to uart_clk.
REQ-007 Port rx_out  output  DATA_WIDTH: last correctly received data word.
REQ-008 Port rx_done  output  1: one-cycle pulse when rx_out has been updated.
REQ-009 Port frame_err  output  1: one-cycle pulse when a frame fails the stop-bit check (or parity check, REQ-031).

Function
REQ-010 Frame format: 1 start bit (0), DATA_WIDTH data bits LSB first, optional parity bit (REQ-030), 1 stop bit (1).
REQ-011 rx_in passes through a 2-flop synchronizer; all decisions use the synchronized value (rx_s); input-to-rx_s latency is 2 cycles.
REQ-012 The FSM has states IDLE, START, DATA, PARITY (only when REQ-030 is compiled in), STOP, and RECOVER.
REQ-013 IDLE: on a 1-to-0 transition of rx_s, go to START and clear the bit counter (bit_cnt) and the cycle counter (cyc_cnt).
REQ-014 START: at cyc_cnt == CYCLES_PER_BIT/2 - 1, sample rx_s; if 0, go to DATA with cyc_cnt = 0; if 1 (glitch), go to IDLE with no output pulse.
REQ-015 DATA: at each cyc_cnt == CYCLES_PER_BIT - 1, shift rx_s into the shift register at bit position bit_cnt and increment bit_cnt; after DATA_WIDTH samples, go to PARITY or STOP.
REQ-016 STOP: at cyc_cnt == CYCLES_PER_BIT - 1, sample rx_s. If 1: load rx_out, pulse rx_done for exactly 1 cycle, go to IDLE. If 0: pulse frame_err for 1 cycle, leave rx_out unchanged, go to RECOVER.
REQ-017 RECOVER: wait until rx_s == 1, then go to IDLE; falling edges in this state do not start a frame.
REQ-018 rx_out changes only in the same cycle that rx_done is asserted; rx_done and frame_err are never asserted together.
REQ-019 Because stop sampling occurs mid-bit, a new start edge is accepted from IDLE in the following half bit; back-to-back frames with no idle gap are received without loss.
REQ-020 cyc_cnt width is $clog2(CYCLES_PER_BIT); bit_cnt width is $clog2(DATA_WIDTH+1); neither counter wraps within a state.

Reset
REQ-021 While rst_n = 0: FSM = IDLE, counters = 0, shift register = 0, rx_out = 0, rx_done = 0, frame_err = 0, and synchronizer flops = 1.
REQ-022 Reset asserted mid-frame aborts the frame immediately with no rx_done or frame_err pulse; after release, the block waits for a fresh falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN: when defined, a PARITY state follows DATA and samples one even-parity bit at mid-bit; when undefined, DATA goes directly to STOP and frames are 10 bits at default width.
REQ-031 With UART_RX_PARITY_EN defined, a parity mismatch combined with a valid stop bit pulses frame_err at the stop sample, leaves rx_out unchanged, and goes to IDLE.

Structure
REQ-040 Shared package uart_pkg holds the FSM state enum (uart_rx_state_t) and the default DATA_WIDTH, BPS and SYS_CLK_FREQ constants.
REQ-041 The synchronizer is a sub-module, uart_sync2, parameterized with the reset value 1.

Verification
REQ-050 Send 0x55 at 9600 bps -> rx_out = 0x55, one rx_done pulse about 9.5 bit times after the start edge, and frame_err = 0.
REQ-051 Send 0xA3 then 0x0F back-to-back with no idle gap -> two rx_done pulses with rx_out = 0xA3 then 0x0F.
REQ-052 Drive a 1000-cycle low glitch on an idle line -> no rx_done, no frame_err, and the FSM returns to IDLE.
REQ-053 Send 0x3C with stop bit = 0 -> one frame_err pulse, rx_out keeps its previous value, and no frame is accepted until the line returns high.
REQ-054 Assert rst_n low during data bit 4 of a frame, then send 0x81 -> no pulse from the aborted frame, then rx_out = 0x81.
REQ-055 Loop back from the team's transmitter block sending 0x00 and 0xFF -> both words received exactly; with UART_RX_PARITY_EN, a flipped parity bit gives frame_err and no rx_done.
